// File: rtl/regfile_32x64_if.sv
// Register-file access bundle: WB-stage write request plus two ID-stage read ports.
// The master drives the write request and read indices; the register file (slave)
// returns the read data.
interface regfile_32x64_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file for the ID stage of the 5-stage pipeline.
// Write address is decoded through a 1-to-4 / 1-to-8 demux tree into one-hot
// per-register enables; two combinational read ports. Register ZERO_REG (XZR)
// always reads as zero and can never be written.
// Optional build macro: REGFILE_BYPASS_EN -- forwards the same-cycle WB write
// data onto a read port addressing the register being written.
module regfile_32x64 #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_32x64_if.slave        bus
);
    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam int                SUB_W    = ADDR_W - 2;
    localparam int                SUB_N    = 1 << SUB_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [3:0]          grp_en_s;
    logic [NUM_REGS-1:0] en_s;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];

    // First demux stage: the two top address bits select one of four groups.
    always_comb begin
        grp_en_s = 4'b0000;
        if (bus.RegWrite) begin
            case (bus.WriteRegister[ADDR_W-1 -: 2])
                2'd0:    grp_en_s = 4'b0001;
                2'd1:    grp_en_s = 4'b0010;
                2'd2:    grp_en_s = 4'b0100;
                2'd3:    grp_en_s = 4'b1000;
                default: grp_en_s = 4'b0000;
            endcase
        end else begin
            grp_en_s = 4'b0000;
        end
    end

    // Second demux stage: the low address bits pick one register inside the group; XZR never enabled.
    always_comb begin
        en_s = '0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < SUB_N; k++) begin
                en_s[g*SUB_N + k] = grp_en_s[g] & (bus.WriteRegister[SUB_W-1:0] == SUB_W'(k));
            end
        end
        en_s[ZERO_REG] = 1'b0;
    end

    // Register storage: synchronous reset clears everything and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (en_s[i]) begin
                    regs_r[i] <= bus.WriteData;
                end
            end
        end
    end

    // Read port A: 32:1 mux, XZR forced to zero, optional same-cycle forwarding of the WB write.
    always_comb begin
        bus.ReadData1 = '0;
        if (bus.ReadRegister1 == ZERO_IDX) begin
            bus.ReadData1 = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (bus.RegWrite && !reset && (bus.WriteRegister == bus.ReadRegister1)) begin
            bus.ReadData1 = bus.WriteData;
`endif
        end else begin
            bus.ReadData1 = regs_r[bus.ReadRegister1];
        end
    end

    // Read port B: identical to port A on its own index.
    always_comb begin
        bus.ReadData2 = '0;
        if (bus.ReadRegister2 == ZERO_IDX) begin
            bus.ReadData2 = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (bus.RegWrite && !reset && (bus.WriteRegister == bus.ReadRegister2)) begin
            bus.ReadData2 = bus.WriteData;
`endif
        end else begin
            bus.ReadData2 = regs_r[bus.ReadRegister2];
        end
    end
endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: a reference array tracks the expected
// register contents; expected read results are queued when read indices are
// driven and popped/compared once the combinational outputs have settled.
module tb_regfile_32x64;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk;
    logic reset;

    regfile_32x64_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

    regfile_32x64 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] model [32];
    logic [DATA_W-1:0] exp_q [$];
    string             tag_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected combinational read value given the model and the current write inputs.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (a == 5'd31) begin
            v = 64'h0;
        end else begin
            v = model[a];
`ifdef REGFILE_BYPASS_EN
            if (rf_if.RegWrite === 1'b1 && reset === 1'b0 && rf_if.WriteRegister == a)
                v = rf_if.WriteData;
`endif
        end
        return v;
    endfunction

    // Drive both read indices, queue expectations, then pop and compare after settling.
    task automatic check_reads(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                               input string tag);
        rf_if.ReadRegister1 = a;
        rf_if.ReadRegister2 = b;
        exp_q.push_back(exp_read(a)); tag_q.push_back($sformatf("%s rd1[%0d]", tag, a));
        exp_q.push_back(exp_read(b)); tag_q.push_back($sformatf("%s rd2[%0d]", tag, b));
        #1;
        check_val(tag_q.pop_front(), rf_if.ReadData1, exp_q.pop_front());
        check_val(tag_q.pop_front(), rf_if.ReadData2, exp_q.pop_front());
    endtask

    // Set up a write request (and reset) away from the active edge.
    task automatic drive_write(input logic we, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic rst);
        @(negedge clk);
        rf_if.RegWrite      = we;
        rf_if.WriteRegister = a;
        rf_if.WriteData     = d;
        reset               = rst;
    endtask

    // Take the active edge, update the reference model, then release the request.
    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (rf_if.RegWrite && rf_if.WriteRegister != 5'd31) begin
            model[rf_if.WriteRegister] = rf_if.WriteData;
        end
        #1;
        rf_if.RegWrite = 1'b0;
        reset          = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        rf_if.RegWrite      = 1'b0;
        rf_if.WriteRegister = 5'd0;
        rf_if.WriteData     = 64'h0;
        rf_if.ReadRegister1 = 5'd0;
        rf_if.ReadRegister2 = 5'd0;
        reset               = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        pat = 64'h0101_0101_0101_0101;

        // Reset for one edge, then every address reads zero on both ports.
        drive_write(1'b0, 5'd0, 64'h0, 1'b1);
        clock_edge();
        for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(i), "reset");

        // Write sweep; after each write check the target, a neighbour and XZR.
        for (int i = 0; i < 31; i++) begin
            drive_write(1'b1, 5'(i), 64'(i) * pat, 1'b0);
            clock_edge();
            check_reads(5'(i), 5'((i + 1) % 31), "sweep");
            check_reads(5'(i), 5'd31, "sweep_xzr");
        end
        for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(i), "readback");

        // XZR write is discarded.
        drive_write(1'b1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        clock_edge();
        check_reads(5'd31, 5'd30, "xzr");

        // Write gating: RegWrite low leaves reg5 alone, also with unknown address/data.
        drive_write(1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        clock_edge();
        check_reads(5'd5, 5'd4, "gate");
        drive_write(1'b0, 'x, 'x, 1'b0);
        clock_edge();
        check_reads(5'd5, 5'd6, "gate_x");

        // Random writes, including repeated overwrites.
        for (int n = 0; n < 20; n++) begin
            ra = 5'($urandom_range(0, 31));
            rd = {$urandom, $urandom};
            drive_write(1'b1, ra, rd, 1'b0);
            clock_edge();
            check_reads(ra, 5'($urandom_range(0, 31)), "rand");
        end

        // Reset priority: a write on the reset edge is dropped and everything clears.
        drive_write(1'b1, 5'd7, 64'h1234, 1'b1);
        clock_edge();
        for (int i = 0; i < 32; i++) check_reads(5'(i), 5'(31 - i), "rst_prio");

        // Same-cycle read-after-write on reg 3.
        drive_write(1'b1, 5'd3, 64'h5555, 1'b0);
        clock_edge();
        drive_write(1'b1, 5'd3, 64'hABCD, 1'b0);
        check_reads(5'd3, 5'd3, "raw_pre");
        clock_edge();
        check_reads(5'd3, 5'd2, "raw_post");

        // Write to XZR with a read of 31 in the same cycle never forwards.
        drive_write(1'b1, 5'd31, 64'h7777, 1'b0);
        check_reads(5'd31, 5'd3, "xzr_same");
        clock_edge();

        if (exp_q.size() != 0) begin
            check_val("queue_drain", 64'(exp_q.size()), 64'h0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
